// File: rtl/fifo_ram_ctrl.sv
// fifo_ram_ctrl: synchronous FIFO controller acting as initiator of one
// external 16 x 8 RAM (5-bit address ports, registered 1-cycle read).
// Converts push/pop requests into RAM write/read strobes and addresses,
// tracks occupancy, and reports full/empty plus sticky overflow/underflow.
module fifo_ram_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,

    // user side
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,

    // RAM side
    output logic              ram_write_enable,
    output logic [4:0]        ram_write_addr,
    output logic [DATA_W-1:0] ram_write_data,
    output logic              ram_read_enable,
    output logic [4:0]        ram_read_addr,
    input  logic [DATA_W-1:0] ram_read_data
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned RAM_AW = 5;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_acc;
    logic              pop_acc;
    logic [CNT_W-1:0]  count_nxt;

    // Accept rules; reset suppresses both so nothing reaches the RAM.
    // At full, a same-cycle accepted pop frees the slot for the push.
    always_comb begin
        pop_acc  = pop  & ~empty & ~rst;
        push_acc = push & (~full | pop_acc) & ~rst;
    end

    // Next occupancy: simultaneous push+pop leaves count unchanged.
    always_comb begin
        count_nxt = count;
        case ({push_acc, pop_acc})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // RAM strobes and addresses come straight from the accept terms and
    // pointers; the upper address bit is unused by a 16-entry array.
    always_comb begin
        ram_write_enable = push_acc;
        ram_write_addr   = RAM_AW'(wr_ptr);
        ram_write_data   = push_data;
        ram_read_enable  = pop_acc;
        ram_read_addr    = RAM_AW'(rd_ptr);
    end

    // RAM read data is already registered, so it is forwarded as-is and
    // lines up with pop_valid one cycle after the accept.
    always_comb begin
        pop_data = ram_read_data;
    end

    // Pointer, occupancy, flag and read-valid state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count     <= count_nxt;
            empty     <= (count_nxt == '0);
            full      <= (count_nxt == CNT_W'(DEPTH));
            pop_valid <= pop_acc;
            if (push & ~push_acc) begin
                overflow <= 1'b1;
            end
            if (pop & ~pop_acc) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// tb_fifo_ram_ctrl: directed scenarios followed by randomized push/pop/reset
// traffic, checked against a queue-based FIFO reference model. The RAM is
// modelled here as a read-first 16 x 8 array with a registered read port.
module tb_fifo_ram_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic          ram_write_enable;
    logic [4:0]    ram_write_addr;
    logic [DW-1:0] ram_write_data;
    logic          ram_read_enable;
    logic [4:0]    ram_read_addr;
    logic [DW-1:0] ram_read_data;

    always #5 clk = ~clk;

    fifo_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .push             (push),
        .push_data        (push_data),
        .pop              (pop),
        .pop_data         (pop_data),
        .pop_valid        (pop_valid),
        .full             (full),
        .empty            (empty),
        .count            (count),
        .overflow         (overflow),
        .underflow        (underflow),
        .ram_write_enable (ram_write_enable),
        .ram_write_addr   (ram_write_addr),
        .ram_write_data   (ram_write_data),
        .ram_read_enable  (ram_read_enable),
        .ram_read_addr    (ram_read_addr),
        .ram_read_data    (ram_read_data)
    );

    // Read-first RAM: a same-address read and write returns the old word.
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (ram_read_enable) ram_read_data <= mem[ram_read_addr[3:0]];
        if (ram_write_enable) mem[ram_write_addr[3:0]] <= ram_write_data;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [DW-1:0] q[$];
    int            wr_idx = 0;
    int            rd_idx = 0;
    bit            m_ovf  = 1'b0;
    bit            m_unf  = 1'b0;
    bit            m_pv   = 1'b0;
    logic [DW-1:0] m_pd   = '0;

    // One clock cycle: apply inputs, check RAM strobes, clock, check state.
    task automatic step(input bit r, input bit pu, input bit po, input logic [DW-1:0] d);
        bit uacc;
        bit pacc;
        rst = r; push = pu; pop = po; push_data = d;
        #1;
        uacc = !r && po && (q.size() != 0);
        pacc = !r && pu && ((q.size() < DEPTH) || uacc);
        check("ram_write_enable", 32'(ram_write_enable), 32'(pacc));
        check("ram_read_enable", 32'(ram_read_enable), 32'(uacc));
        if (pacc) begin
            check("ram_write_addr", 32'(ram_write_addr), 32'(wr_idx));
            check("ram_write_data", 32'(ram_write_data), 32'(d));
        end
        if (uacc) check("ram_read_addr", 32'(ram_read_addr), 32'(rd_idx));
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            wr_idx = 0; rd_idx = 0;
            m_ovf = 1'b0; m_unf = 1'b0; m_pv = 1'b0;
        end else begin
            m_pv = uacc;
            if (uacc) begin
                m_pd   = q.pop_front();
                rd_idx = (rd_idx + 1) % DEPTH;
            end
            if (pacc) begin
                q.push_back(d);
                wr_idx = (wr_idx + 1) % DEPTH;
            end
            if (pu && !pacc) m_ovf = 1'b1;
            if (po && !uacc) m_unf = 1'b1;
        end
        check("count", 32'(count), 32'(q.size()));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
        check("pop_valid", 32'(pop_valid), 32'(m_pv));
        if (m_pv) check("pop_data", 32'(pop_data), 32'(m_pd));
    endtask

    initial begin
        int p_push;
        int p_pop;

        // Reset for two cycles
        step(1'b1, 1'b1, 1'b1, 8'h55);
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // Three pushes then three pops
        step(1'b0, 1'b1, 1'b0, 8'hA1);
        step(1'b0, 1'b1, 1'b0, 8'hB2);
        step(1'b0, 1'b1, 1'b0, 8'hC3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Fill, overflow attempt, drain
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        step(1'b0, 1'b1, 1'b0, 8'h99);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Pointer wrap: two rounds of 10 in, 10 out
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + 8'(k * 16 + i)));
            for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Full with simultaneous push/pop, then drain
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h80 + 8'(i)));
        step(1'b0, 1'b1, 1'b1, 8'hEE);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

        // Pop at empty, simultaneous push+pop at empty, reset mid-stream
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h3C);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h60 + 8'(i)));
        step(1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Randomized traffic with varying push/pop bias and rare resets
        for (int ph = 0; ph < 12; ph++) begin
            p_push = int'($urandom_range(10, 90));
            p_pop  = int'($urandom_range(10, 90));
            for (int i = 0; i < 200; i++) begin
                step(($urandom_range(0, 299) == 0),
                     (int'($urandom_range(0, 99)) < p_push),
                     (int'($urandom_range(0, 99)) < p_pop),
                     8'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
